// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state type and default widths/reset PC for the fetch sequencer
package fetch_ctrl_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, issues imem requests and buffers one instruction toward decode
module fetch_ctrl #(
  parameter int XLEN = fetch_ctrl_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_ctrl_pkg::RESET_PC,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted
);
  import fetch_ctrl_pkg::*;
  fetch_state_t state, state_next;
  logic [XLEN-1:0] pc;
  logic load;
  // A redirect in the ack cycle discards the returned word.
  assign load = state == REQ && imem_ack && !redirect_valid;
  assign imem_req = state == REQ;
  assign imem_addr = pc;
  assign instr_valid = state == HOLD;
  assign halted = state == HALTED;
  always_comb begin
    state_next = redirect_valid ? REQ :
                 state == IDLE  ? REQ :
                 state == REQ   ? (imem_ack ? HOLD : halt ? HALTED : REQ) :
                 state == HOLD  ? (instr_ready ? (halt ? HALTED : REQ) : HOLD) :
                 HALTED;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      instr <= '0;
      instr_pc <= '0;
    end else begin
      pc <= redirect_valid ? redirect_pc : load ? pc + XLEN'(PC_STEP) : pc;
      if (load) begin
        instr <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized run checked against a transaction-level fetch model
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n, imem_req, imem_ack, instr_valid, instr_ready, redirect_valid, halt, halted;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_instr, m_ipc;
  bit m_buf, m_halted, m_started;

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction
  assign imem_rdata = mem(imem_addr);

  task automatic model_reset;
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
    m_buf = 0; m_halted = 0; m_started = 0;
  endtask

  // Advance one clock; the model applies the fetch rules to the inputs seen at the edge.
  task automatic tick;
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (redirect_valid) begin m_pc = redirect_pc; m_buf = 0; m_halted = 0; m_started = 1; end
    else if (!m_started) m_started = 1;
    else if (m_buf) begin if (instr_ready) begin m_buf = 0; m_halted = halt; end end
    else if (!m_halted) begin
      if (imem_ack) begin m_buf = 1; m_instr = mem(m_pc); m_ipc = m_pc; m_pc = m_pc + 32'd4; end
      else if (halt) m_halted = 1;
    end
    #1;
  endtask

  task automatic test_reset;
    rst_n = 0; imem_ack = 0; instr_ready = 0; redirect_valid = 0; redirect_pc = 0; halt = 0;
    model_reset();
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", instr_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %0b want 0", halted); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    checks++; if ({instr, instr_pc} !== 64'h0) begin errors++; $display("FAIL rst_buf: got %h/%h want 0/0", instr, instr_pc); end
    rst_n = 1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL quiet_cycle: got %0b want 0", imem_req); end
    tick();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL first_req: got %0b/%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_sequential;
    imem_ack = 1; instr_ready = 1;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({imem_req, imem_addr} !== {1'b1, 32'(4 * k)}) begin errors++; $display("FAIL seq_addr%0d: got %0b/%h want 1/%h", k, imem_req, imem_addr, 4 * k); end
      tick();
      checks++; if ({instr_valid, imem_req, instr_pc, instr} !== {2'b10, 32'(4 * k), mem(32'(4 * k))})
        begin errors++; $display("FAIL seq_instr%0d: got v=%0b r=%0b pc=%h i=%h want pc=%h i=%h", k, instr_valid, imem_req, instr_pc, instr, 4 * k, mem(32'(4 * k))); end
      tick();
    end
  endtask

  task automatic test_backpressure;
    imem_ack = 0; instr_ready = 0;
    repeat (3) begin
      tick();
      checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin errors++; $display("FAIL wait_addr: got %0b/%h want 1/10", imem_req, imem_addr); end
    end
    imem_ack = 1;
    tick();
    imem_ack = 0;
    repeat (5) begin
      checks++; if ({instr_valid, imem_req, instr_pc, instr, imem_addr} !== {2'b10, 32'h10, mem(32'h10), 32'h14})
        begin errors++; $display("FAIL bp_hold: got v=%0b r=%0b pc=%h i=%h a=%h", instr_valid, imem_req, instr_pc, instr, imem_addr); end
      tick();
    end
    instr_ready = 1;
    tick();
    checks++; if ({instr_valid, imem_req, imem_addr} !== {2'b01, 32'h14}) begin errors++; $display("FAIL bp_release: got v=%0b r=%0b a=%h want 0/1/14", instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_redirect_hold;
    instr_ready = 0; imem_ack = 0; redirect_valid = 1; redirect_pc = 32'h8;
    tick();
    redirect_valid = 0; imem_ack = 1;
    tick();
    checks++; if ({instr_valid, instr_pc} !== {1'b1, 32'h8}) begin errors++; $display("FAIL rh_buf8: got %0b/%h want 1/8", instr_valid, instr_pc); end
    imem_ack = 0; redirect_valid = 1; redirect_pc = 32'h40;
    tick();
    checks++; if ({instr_valid, imem_req, imem_addr} !== {2'b01, 32'h40}) begin errors++; $display("FAIL rh_drop: got v=%0b r=%0b a=%h want 0/1/40", instr_valid, imem_req, imem_addr); end
    redirect_valid = 0; imem_ack = 1;
    tick();
    checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h40, mem(32'h40)}) begin errors++; $display("FAIL rh_target: got v=%0b pc=%h i=%h want pc=40", instr_valid, instr_pc, instr); end
    imem_ack = 0; instr_ready = 1;
    tick();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h44}) begin errors++; $display("FAIL rh_next: got %0b/%h want 1/44", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_ack;
    redirect_valid = 1; redirect_pc = 32'h10; imem_ack = 0; instr_ready = 0;
    tick();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin errors++; $display("FAIL ra_fetch10: got %0b/%h want 1/10", imem_req, imem_addr); end
    redirect_pc = 32'h80; imem_ack = 1;
    tick();
    checks++; if ({instr_valid, imem_req, imem_addr} !== {2'b01, 32'h80}) begin errors++; $display("FAIL ra_collide: got v=%0b r=%0b a=%h want 0/1/80", instr_valid, imem_req, imem_addr); end
    redirect_valid = 0;
    tick();
    checks++; if ({instr_valid, instr_pc, imem_addr} !== {1'b1, 32'h80, 32'h84}) begin errors++; $display("FAIL ra_deliver: got v=%0b pc=%h a=%h want 1/80/84", instr_valid, instr_pc, imem_addr); end
    instr_ready = 1; imem_ack = 0;
    tick();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h84}) begin errors++; $display("FAIL ra_next: got %0b/%h want 1/84", imem_req, imem_addr); end
  endtask

  task automatic test_halt;
    redirect_valid = 1; redirect_pc = 32'h20; imem_ack = 0; instr_ready = 0;
    tick();
    redirect_valid = 0; imem_ack = 1;
    tick();
    checks++; if ({instr_valid, instr_pc} !== {1'b1, 32'h20}) begin errors++; $display("FAIL halt_buf: got %0b/%h want 1/20", instr_valid, instr_pc); end
    halt = 1; instr_ready = 1;
    tick();
    checks++; if ({halted, instr_valid} !== 2'b10) begin errors++; $display("FAIL halt_enter: got h=%0b v=%0b want 1/0", halted, instr_valid); end
    repeat (10) begin
      tick();
      checks++; if ({halted, imem_req, imem_addr} !== {2'b10, 32'h24}) begin errors++; $display("FAIL halt_stay: got h=%0b r=%0b a=%h want 1/0/24", halted, imem_req, imem_addr); end
    end
    redirect_valid = 1; redirect_pc = 32'h100;
    tick();
    checks++; if ({halted, imem_req, imem_addr} !== {2'b01, 32'h100}) begin errors++; $display("FAIL halt_resume: got h=%0b r=%0b a=%h want 0/1/100", halted, imem_req, imem_addr); end
    redirect_valid = 0; halt = 0;
    tick();
    checks++; if ({instr_valid, instr_pc} !== {1'b1, 32'h100}) begin errors++; $display("FAIL halt_fetch: got %0b/%h want 1/100", instr_valid, instr_pc); end
    imem_ack = 0;
    tick();
  endtask

  task automatic test_wrap;
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 0; instr_ready = 0;
    tick();
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h want fffffffc", imem_addr); end
    redirect_valid = 0; imem_ack = 1;
    tick();
    checks++; if ({instr_pc, imem_addr} !== {32'hFFFF_FFFC, 32'h0}) begin errors++; $display("FAIL wrap_pc: got pc=%h a=%h want fffffffc/0", instr_pc, imem_addr); end
    instr_ready = 1; imem_ack = 0;
    tick();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL wrap_next: got %0b/%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_async_reset;
    redirect_valid = 1; redirect_pc = 32'h200; imem_ack = 0;
    tick();
    redirect_valid = 0;
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++; if ({imem_req, instr_valid, halted, imem_addr} !== {3'b000, 32'h0}) begin errors++; $display("FAIL async_rst: got r=%0b v=%0b h=%0b a=%h want 0/0/0/0", imem_req, instr_valid, halted, imem_addr); end
    imem_ack = 1;
    tick();
    checks++; if ({imem_req, instr_valid, instr} !== {2'b00, 32'h0}) begin errors++; $display("FAIL rst_ack_ignored: got r=%0b v=%0b i=%h", imem_req, instr_valid, instr); end
    rst_n = 1; imem_ack = 0;
    tick();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rst_restart: got %0b/%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 600; n++) begin
      redirect_valid = $urandom_range(0, 15) == 0;
      redirect_pc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_FFFC);
      halt = $urandom_range(0, 9) == 0;
      imem_ack = $urandom_range(0, 2) != 0;
      instr_ready = $urandom_range(0, 2) != 0;
      tick();
      checks++; if ({imem_req, instr_valid, halted, imem_addr} !== {m_started && !m_buf && !m_halted, m_buf, m_halted, m_pc})
        begin errors++; $display("FAIL rand_ctl@%0d: got r=%0b v=%0b h=%0b a=%h want r=%0b v=%0b h=%0b a=%h", n, imem_req, instr_valid, halted, imem_addr, m_started && !m_buf && !m_halted, m_buf, m_halted, m_pc); end
      if (m_buf) begin
        checks++; if ({instr, instr_pc} !== {m_instr, m_ipc}) begin errors++; $display("FAIL rand_buf@%0d: got i=%h pc=%h want i=%h pc=%h", n, instr, instr_pc, m_instr, m_ipc); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_hold();
    test_redirect_ack();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the rv32i core. It owns the PC, drives the instruction-memory request/address, and buffers one fetched instruction toward decode with a valid/ready handshake. It accepts PC redirects from branch/jump resolution and a halt request. It replaces the free-running PC register in top, so instr_mem.addr is driven from imem_addr.

Parameters:
XLEN, 32, datapath/address width.
RESET_PC, 32'h0000_0000, PC loaded on reset.
PC_STEP, 4, PC increment per fetched instruction.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request; imem_addr valid while high.
imem_addr  out  XLEN  fetch address (= pc).
imem_ack  in  1  imem_rdata valid this cycle; may be asserted in the same cycle as imem_req or later.
imem_rdata  in  32  fetched instruction word.
instr_valid  out  1  instr/instr_pc valid toward decode.
instr_ready  in  1  decode accepts the instruction.
instr  out  32  buffered instruction.
instr_pc  out  XLEN  PC of the buffered instruction.
redirect_valid  in  1  load redirect_pc as the new PC (taken branch, jal, jalr).
redirect_pc  in  XLEN  redirect target.
halt  in  1  stop fetching (ecall/ebreak/end of test); level-sensitive.
halted  out  1  high while in HALTED.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, halted=0.
- States: IDLE, REQ, HOLD, HALTED. imem_req=1 only in REQ. imem_addr=pc at all times.
- IDLE -> REQ unconditionally on the first clock after reset release. This gives one quiet cycle.
- REQ:
  - imem_ack=1: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_STEP, next state HOLD.
  - imem_ack=0: stay in REQ; addr held.
- HOLD:
  - instr_valid=1, instr and instr_pc held stable.
  - On handshake (instr_valid & instr_ready): instr_valid<=0, next state REQ, or HALTED if halt=1.
  - Without a handshake: stay in HOLD; no request is issued.
- Throughput: one instruction every 2 cycles with zero-wait memory. Fetch latency is addr-to-instr_valid = ack cycle + 1.
- Redirect has the highest priority after reset and applies in any state, including HALTED:
  - pc<=redirect_pc, instr_valid<=0 (buffered instr dropped), next state REQ.
  - An imem_ack in the same cycle is discarded: no buffer load and no PC increment.
  - Memory tolerates abandoned requests, so imem_addr may change while imem_req=1.
- Halt (below redirect in priority):
  - In REQ with halt=1 and no ack, the request is abandoned and the state goes to HALTED with pc unchanged.
  - In REQ with halt=1 and ack=1, the instruction is still buffered, next state HOLD. It then goes to HALTED on acceptance.
  - HALTED exits only on redirect_valid.
  - halted=1 and imem_req=0 in HALTED.
- Arithmetic: pc+PC_STEP wraps modulo 2^XLEN (32'hFFFF_FFFC+4 -> 0). No alignment check is done.
- Reset mid-request: async clear with the above values. Any ack arriving during reset is ignored.

Decomposition:
- rv32i package holds:
  - fetch_state_t enum {IDLE, REQ, HOLD, HALTED};
  - XLEN;
  - RESET_PC default constant.
- No sub-module is required. The output buffer is a single registered entry inside fetch_ctrl.

Test Plan:
1. Sequential fetch: release reset, imem_ack=1 and instr_ready=1 tied -> imem_req=0 in the first cycle, then imem_addr 0,4,8,12 issued every 2 cycles; instr_pc sequence 0,4,8 with instr matching memory.
2. Wait states and backpressure: ack delayed 3 cycles, then instr_ready=0 for 5 cycles -> imem_addr stable during the wait; instr_valid held, instr/instr_pc stable, imem_req=0 and pc=+4 unchanged until accepted.
3. Redirect in HOLD: buffered pc=8, redirect_pc=0x40 -> instr_valid=0 next cycle, next imem_addr=0x40, pc=0x40 instruction delivered.
4. Redirect colliding with ack: redirect_valid=1 and imem_ack=1 in the same cycle (fetching 0x10, target 0x80) -> no instr_valid for 0x10 data, next request at 0x80, then 0x84.
5. Halt and resume: halt=1 while pc=0x20 instruction is in HOLD -> accepted, halted=1, imem_req=0 for 10 cycles; redirect 0x100 -> halted=0, fetch resumes at 0x100.
6. Wrap and async reset: redirect to 0xFFFF_FFFC -> next fetch address 0x0. Assert rst_n=0 mid-REQ (between clock edges) -> imem_req, instr_valid and halted drop immediately and pc=RESET_PC.
